// File: rtl/ama_riscv_pkg.sv
// ama_riscv_pkg
//   Shared types and constants for the ama_riscv UART peripheral.
//   - uart_tx_state_t : transmit FSM states
//   - uart_rx_state_t : receive FSM states
//   - UART_DATA_BITS  : payload bits per frame (8N1)
//   Both enums hold IDLE/START/DATA/STOP. They carry TX_/RX_ prefixes
//   because they share this package's scope and would otherwise clash.

package ama_riscv_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } uart_tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } uart_rx_state_t;

endpackage

// File: rtl/ama_riscv_uart_rx_fifo.sv
// ama_riscv_uart_rx_fifo
//   Synchronous first-word-fall-through FIFO for received UART bytes.
//   It is used only when the top is built with UART_RX_FIFO_EN.
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     push, push_data   write request and byte
//     pop               consume the head entry
//     head_data         current head entry (valid when !empty)
//     full, empty       occupancy flags
//   The pointers are one bit wider than the address, and that extra bit
//   is the wrap bit. A push into a full FIFO succeeds only when a pop
//   happens in the same cycle.

module ama_riscv_uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr[AW-1:0]];

    // Storage is cleared on reset so that the head reads 0 before the first byte arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ama_riscv_uart.sv
// ama_riscv_uart
//   MMIO UART peripheral. It is the far end of the core's uart_send_req
//   and uart_recv_rsp channels and uses 8N1 framing, LSB first.
//   Ports:
//     clk, rst_n                          clock, async active-low reset
//     send_req_valid/data/ready           TX byte handshake (ready = TX idle)
//     recv_rsp_valid/data/ready           RX byte handshake
//     rx_overrun                          1-cycle pulse when a received byte is dropped
//     serial_rx, serial_tx                board serial pins, both idle high
//   Configuration macro: UART_RX_FIFO_EN
//     Undefined: a single receive holding register.
//     Defined:   an RX_FIFO_DEPTH-entry FWFT FIFO (ama_riscv_uart_rx_fifo).

module ama_riscv_uart
    import ama_riscv_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 100_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      send_req_valid,
    input  logic [UART_DATA_BITS-1:0] send_req_data,
    output logic                      send_req_ready,
    output logic                      recv_rsp_valid,
    output logic [UART_DATA_BITS-1:0] recv_rsp_data,
    input  logic                      recv_rsp_ready,
    output logic                      rx_overrun,
    input  logic                      serial_rx,
    output logic                      serial_tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);

    // A bit period this short leaves no room for the half-bit start check.
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("ama_riscv_uart: CLKS_PER_BIT must be at least 4");
    end

    if (RX_FIFO_DEPTH < 1) begin : g_bad_depth
        $error("ama_riscv_uart: RX_FIFO_DEPTH must be positive");
    end

    // ---------------------------------------------------------------- TX
    uart_tx_state_t            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]          tx_cnt_q, tx_cnt_d;
    logic [2:0]                tx_idx_q, tx_idx_d;
    logic [UART_DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                      tx_bit_q, tx_bit_d;
    logic                      tx_ready_q, tx_ready_d;

    assign serial_tx      = tx_bit_q;
    assign send_req_ready = tx_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_bit_q   <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    // Ready is computed from the current state. It therefore rises one cycle
    // after the FSM re-enters IDLE and drops on the same edge that accepts a byte.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_ready_d = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_bit_d   = 1'b1;
                tx_ready_d = 1'b1;
                if (send_req_valid && send_req_ready) begin
                    tx_state_d = TX_START;
                    tx_shift_d = send_req_data;
                    tx_cnt_d   = '0;
                    tx_bit_d   = 1'b0;
                    tx_ready_d = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_bit_d   = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == IDX_LAST) begin
                        tx_state_d = TX_STOP;
                        tx_bit_d   = 1'b1;
                    end else begin
                        tx_idx_d   = tx_idx_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = TX_IDLE;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- RX
    uart_rx_state_t            rx_state_q, rx_state_d;
    logic [CNT_W-1:0]          rx_cnt_q, rx_cnt_d;
    logic [2:0]                rx_idx_q, rx_idx_d;
    logic [UART_DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [1:0]                rx_sync_q;
    logic                      rx_line;
    logic                      rx_commit;
    logic                      rx_drop;

    assign rx_line = rx_sync_q[1];

    // The synchronizer resets to the idle level so that reset release does not look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], serial_rx};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // START checks the line half a bit after the falling edge. From then on,
    // each full-bit wait lands in the middle of the next bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_commit  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_line) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_line ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_line, rx_shift_q[UART_DATA_BITS-1:1]};
                    if (rx_idx_q == IDX_LAST) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_state_d = RX_IDLE;
                    rx_cnt_d   = '0;
                    rx_commit  = rx_line;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------------------------------------------------- RX storage
`ifdef UART_RX_FIFO_EN
    logic rx_full;
    logic rx_empty;
    logic rx_pop;

    if ((RX_FIFO_DEPTH < 2) || ((RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo
        $error("ama_riscv_uart: RX_FIFO_DEPTH must be a power of 2, at least 2");
    end

    assign rx_pop         = recv_rsp_valid && recv_rsp_ready;
    assign recv_rsp_valid = !rx_empty;
    assign rx_drop        = rx_commit && rx_full && !rx_pop;

    ama_riscv_uart_rx_fifo #(
        .DEPTH (RX_FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_commit),
        .push_data (rx_shift_q),
        .pop       (rx_pop),
        .head_data (recv_rsp_data),
        .full      (rx_full),
        .empty     (rx_empty)
    );
`else
    logic                      hold_valid_q;
    logic [UART_DATA_BITS-1:0] hold_data_q;

    assign recv_rsp_valid = hold_valid_q;
    assign recv_rsp_data  = hold_data_q;
    assign rx_drop        = rx_commit && hold_valid_q && !recv_rsp_ready;

    // A commit that coincides with a pop replaces the byte and keeps valid high.
    // The data register holds the last byte after it has been drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else if (rx_commit && !rx_drop) begin
            hold_valid_q <= 1'b1;
            hold_data_q  <= rx_shift_q;
        end else if (hold_valid_q && recv_rsp_ready) begin
            hold_valid_q <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= rx_drop;
        end
    end

endmodule
